// File: rtl/fft_pkg.sv
// Shared widths, complex/twiddle types, twiddle constants and saturation helpers for the FFT butterfly.
package fft_pkg;

  localparam int unsigned DW    = 16;      // sample component width, Q8.8
  localparam int unsigned TW    = 8;       // twiddle component width, Q2.6
  localparam int unsigned FRAC  = 6;       // twiddle fraction bits
  localparam int unsigned KW    = 3;       // twiddle index width
  localparam int unsigned NTW   = 8;       // twiddle table depth
  localparam int unsigned AW    = DW + 2;  // butterfly sum width, wide enough for A +/- (p - q)
  localparam int unsigned NLANE = 4;       // x_re, x_im, y_re, y_im

  typedef struct packed {
    logic signed [DW-1:0] re;
    logic signed [DW-1:0] im;
  } cplx_t;

  typedef struct packed {
    logic signed [TW-1:0] re;
    logic signed [TW-1:0] im;
  } twid_t;

  // W_k = e^(-j*2*pi*k/16), Q2.6
  localparam twid_t TWIDDLE [NTW] = '{
    '{ 8'sd64,   8'sd0  },
    '{ 8'sd59,  -8'sd24 },
    '{ 8'sd45,  -8'sd45 },
    '{ 8'sd24,  -8'sd59 },
    '{ 8'sd0,   -8'sd64 },
    '{-8'sd24,  -8'sd59 },
    '{-8'sd45,  -8'sd45 },
    '{-8'sd59,  -8'sd24 }
  };

  // True when v lies outside the DW-bit signed range.
  function automatic logic is_sat(input logic signed [AW-1:0] v);
    logic signed [AW-1:0] v_max;
    logic signed [AW-1:0] v_min;
    v_max = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    v_min = {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};
    return (v > v_max) || (v < v_min);
  endfunction

  // Clamp an AW-bit signed value to the DW-bit signed range.
  function automatic logic signed [DW-1:0] sat16(input logic signed [AW-1:0] v);
    logic signed [AW-1:0] v_max;
    logic signed [AW-1:0] v_min;
    v_max = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    v_min = {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};
    if (v > v_max)      return {1'b0, {(DW-1){1'b1}}};
    else if (v < v_min) return {1'b1, {(DW-1){1'b0}}};
    else                return v[DW-1:0];
  endfunction

endpackage

// File: rtl/fft_butterfly_pipe_if.sv
// Valid/ready operand and result bundle of the butterfly, plus the sticky overflow flag.
interface fft_butterfly_pipe_if;
  import fft_pkg::*;

  logic                 in_valid;
  logic                 in_ready;
  logic signed [DW-1:0] a_re;
  logic signed [DW-1:0] a_im;
  logic signed [DW-1:0] b_re;
  logic signed [DW-1:0] b_im;
  logic [KW-1:0]        k;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [DW-1:0] x_re;
  logic signed [DW-1:0] x_im;
  logic signed [DW-1:0] y_re;
  logic signed [DW-1:0] y_im;
  logic                 ovf;
  logic                 ovf_clr;

  modport master (
    output in_valid, a_re, a_im, b_re, b_im, k, out_ready, ovf_clr,
    input  in_ready, out_valid, x_re, x_im, y_re, y_im, ovf
  );

  modport slave (
    input  in_valid, a_re, a_im, b_re, b_im, k, out_ready, ovf_clr,
    output in_ready, out_valid, x_re, x_im, y_re, y_im, ovf
  );

endinterface

// File: rtl/signed_multiplier.sv
// Signed fixed-point multiply: low OW_P bits of (a*b) >>> FRAC_P, floor rounding, wraps on overflow.
module signed_multiplier #(
  parameter int unsigned AW_P   = 16,
  parameter int unsigned BW_P   = 8,
  parameter int unsigned FRAC_P = 6,
  parameter int unsigned OW_P   = 16
) (
  input  logic signed [AW_P-1:0] i_a,
  input  logic signed [BW_P-1:0] i_b,
  output logic signed [OW_P-1:0] o_p_c
);

  logic signed [AW_P+BW_P-1:0] w_full;

  // Full-precision product, then drop fraction bits and keep the low word.
  assign w_full = i_a * i_b;
  assign o_p_c  = OW_P'(w_full >>> FRAC_P);

endmodule

// File: rtl/twiddle_rom.sv
// Registered twiddle lookup forming the coefficient half of pipeline stage 1.
module twiddle_rom
  import fft_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_en,
  input  logic [KW-1:0] i_k,
  output twid_t         o_w
);

  twid_t r_w;

  // Capture the coefficient for the accepted index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    r_w <= '0;
    else if (i_en) r_w <= TWIDDLE[i_k];
  end

  assign o_w = r_w;

endmodule

// File: rtl/fft_butterfly_pipe.sv
// Three-stage radix-2 DIT butterfly: X = A + B*W_k, Y = A - B*W_k, with a stall-all valid/ready pipeline.
module fft_butterfly_pipe
  import fft_pkg::*;
#(
  parameter bit SCALE = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  fft_butterfly_pipe_if.slave  bus
);

  logic w_en;
  logic w_acc;

  logic  r_s1_valid;
  cplx_t r_s1_a;
  cplx_t r_s1_b;
  twid_t w_s1_w;

  logic signed [DW-1:0] w_rr, w_ii, w_ri, w_ir;

  logic                 r_s2_valid;
  cplx_t                r_s2_a;
  logic signed [DW-1:0] r_s2_rr, r_s2_ii, r_s2_ri, r_s2_ir;

  logic signed [AW-1:0] w_t_re, w_t_im;
  logic signed [AW-1:0] w_pre [NLANE];
  logic signed [AW-1:0] w_scl [NLANE];
  logic signed [DW-1:0] w_res [NLANE];
  logic                 w_sat_any;

  logic  r_s3_valid;
  cplx_t r_x;
  cplx_t r_y;
  logic  r_ovf;

  // Whole pipe advances together; only a held, undrained result stalls it.
  assign w_en         = !r_s3_valid || bus.out_ready;
  assign w_acc        = bus.in_valid && w_en;
  assign bus.in_ready = w_en;

  // Stage valid bits shift with the data, bubbles included.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
      r_s3_valid <= 1'b0;
    end else if (w_en) begin
      r_s1_valid <= bus.in_valid;
      r_s2_valid <= r_s1_valid;
      r_s3_valid <= r_s2_valid;
    end
  end

  // S1: capture operands; the twiddle ROM registers the coefficient alongside.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_a <= '0;
      r_s1_b <= '0;
    end else if (w_acc) begin
      r_s1_a <= cplx_t'{re: bus.a_re, im: bus.a_im};
      r_s1_b <= cplx_t'{re: bus.b_re, im: bus.b_im};
    end
  end

  twiddle_rom u_twiddle_rom (
    .clk   (clk),
    .rst_n (rst_n),
    .i_en  (w_acc),
    .i_k   (bus.k),
    .o_w   (w_s1_w)
  );

  signed_multiplier #(.AW_P(DW), .BW_P(TW), .FRAC_P(FRAC), .OW_P(DW)) u_mul_rr (
    .i_a (r_s1_b.re), .i_b (w_s1_w.re), .o_p_c (w_rr)
  );
  signed_multiplier #(.AW_P(DW), .BW_P(TW), .FRAC_P(FRAC), .OW_P(DW)) u_mul_ii (
    .i_a (r_s1_b.im), .i_b (w_s1_w.im), .o_p_c (w_ii)
  );
  signed_multiplier #(.AW_P(DW), .BW_P(TW), .FRAC_P(FRAC), .OW_P(DW)) u_mul_ri (
    .i_a (r_s1_b.re), .i_b (w_s1_w.im), .o_p_c (w_ri)
  );
  signed_multiplier #(.AW_P(DW), .BW_P(TW), .FRAC_P(FRAC), .OW_P(DW)) u_mul_ir (
    .i_a (r_s1_b.im), .i_b (w_s1_w.re), .o_p_c (w_ir)
  );

  // S2: register the four partial products and carry A forward.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_a  <= '0;
      r_s2_rr <= '0;
      r_s2_ii <= '0;
      r_s2_ri <= '0;
      r_s2_ir <= '0;
    end else if (w_en && r_s1_valid) begin
      r_s2_a  <= r_s1_a;
      r_s2_rr <= w_rr;
      r_s2_ii <= w_ii;
      r_s2_ri <= w_ri;
      r_s2_ir <= w_ir;
    end
  end

  // Complex product, butterfly sums, optional halving and saturation, all at AW bits.
  always_comb begin
    w_t_re    = AW'($signed(r_s2_rr)) - AW'($signed(r_s2_ii));
    w_t_im    = AW'($signed(r_s2_ri)) + AW'($signed(r_s2_ir));
    w_pre[0]  = AW'($signed(r_s2_a.re)) + w_t_re;
    w_pre[1]  = AW'($signed(r_s2_a.im)) + w_t_im;
    w_pre[2]  = AW'($signed(r_s2_a.re)) - w_t_re;
    w_pre[3]  = AW'($signed(r_s2_a.im)) - w_t_im;
    w_sat_any = 1'b0;
    for (int i = 0; i < NLANE; i++) begin
      w_scl[i]  = SCALE ? (w_pre[i] >>> 1) : w_pre[i];
      w_res[i]  = sat16(w_scl[i]);
      w_sat_any = w_sat_any | is_sat(w_scl[i]);
    end
  end

  // S3: registered butterfly outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x <= '0;
      r_y <= '0;
    end else if (w_en && r_s2_valid) begin
      r_x <= cplx_t'{re: w_res[0], im: w_res[1]};
      r_y <= cplx_t'{re: w_res[2], im: w_res[3]};
    end
  end

  // Sticky overflow; a saturating load in the same cycle beats a clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                             r_ovf <= 1'b0;
    else if (w_en && r_s2_valid && w_sat_any) r_ovf <= 1'b1;
    else if (bus.ovf_clr)                   r_ovf <= 1'b0;
  end

  assign bus.out_valid = r_s3_valid;
  assign bus.x_re      = r_x.re;
  assign bus.x_im      = r_x.im;
  assign bus.y_re      = r_y.re;
  assign bus.y_im      = r_y.im;
  assign bus.ovf       = r_ovf;

endmodule
